// File: rtl/hex_field_entry.sv
// hex_field_entry: collects decoded hex key events into NUM_FIELDS operand
// fields of FIELD_NIBBLES nibbles each, filled MSB-first, with edit keys.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-low reset
//   hex_onehot     decoded hex key, bit k = digit k held
//   backspace      clear last nibble of the active field
//   delete         clear the whole active field
//   enter          commit the active field (only when full)
//   fields         field i at bits [(i+1)*W-1 : i*W], W = 4*FIELD_NIBBLES
//   field_sel      index of the active field
//   char_count     nibbles entered in the active field
//   field_full     char_count == FIELD_NIBBLES
//   hex_accept     one-cycle pulse after a nibble write
//   input_complete all fields committed, held until reset
//   refresh        idle/full with no key held and reset released
//
// Optional macro HEX_FIELD_PREV_EN: backspace on an empty field steps back
// into the previous field so it can be edited again.

module hex_field_entry #(
    parameter int NUM_FIELDS    = 2,
    parameter int FIELD_NIBBLES = 16,
    parameter int SEL_W         = 1,
    parameter int CNT_W         = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [15:0]                         hex_onehot,
    input  logic                                backspace,
    input  logic                                delete,
    input  logic                                enter,
    output logic [NUM_FIELDS*4*FIELD_NIBBLES-1:0] fields,
    output logic [SEL_W-1:0]                    field_sel,
    output logic [CNT_W-1:0]                    char_count,
    output logic                                field_full,
    output logic                                hex_accept,
    output logic                                input_complete,
    output logic                                refresh
);

    localparam int W   = 4 * FIELD_NIBBLES;
    localparam int TOT = NUM_FIELDS * W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIELD_NIBBLES);

    typedef enum logic [1:0] {IDLE, FULL, RELEASE, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [TOT-1:0]     fields_q;
    logic [TOT-1:0]     fields_d;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               acc_q;
    logic               acc_d;
    logic               done_q;
    logic               done_d;

    logic               any_key;
    logic               hex_valid;
    logic [3:0]         digit;
    logic               can_edit;
    logic               bs_ev;
    logic               del_ev;
    logic               ent_ev;
    logic               hex_ev;
    logic               full;
    logic               last_field;
    logic               step_back;
    int                 sel_base;
    int                 cnt_off;
    int                 wr_shift;
    int                 clr_shift;

    assign any_key   = (hex_onehot != 16'd0) || backspace || delete || enter;
    // exactly one bit set: nonzero and clearing the lowest set bit leaves 0
    assign hex_valid = (hex_onehot != 16'd0) &&
                       ((hex_onehot & (hex_onehot - 16'd1)) == 16'd0);

    always_comb begin
        digit = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (hex_onehot[k]) digit = 4'(k);
        end
    end

    assign full       = (cnt_q == CNT_FULL);
    assign last_field = (int'(sel_q) >= NUM_FIELDS - 1);
    assign can_edit   = (state == IDLE) || (state == FULL);

    // key priority: backspace > delete > enter > hex
    assign bs_ev  = can_edit && backspace;
    assign del_ev = can_edit && !backspace && delete;
    assign ent_ev = can_edit && !backspace && !delete && enter;
    assign hex_ev = (state == IDLE) && !full && !backspace && !delete &&
                    !enter && hex_valid;

`ifdef HEX_FIELD_PREV_EN
    assign step_back = (sel_q != '0);
`else
    assign step_back = 1'b0;
`endif

    // bit offsets inside the flat bus; nibble 0 is the field's top nibble
    assign sel_base  = int'(sel_q) * W;
    assign cnt_off   = 4 * int'(cnt_q);
    assign wr_shift  = sel_base + W - 4 - cnt_off;
    assign clr_shift = sel_base + W - cnt_off;

    // state register and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            fields_q <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_next;
            fields_q <= fields_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
        end
    end

    // next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bs_ev || del_ev || ent_ev || hex_ev) state_next = RELEASE;
            end
            FULL: begin
                if (bs_ev || del_ev)  state_next = RELEASE;
                else if (ent_ev)      state_next = last_field ? DONE : RELEASE;
            end
            RELEASE: begin
                if (!any_key) state_next = full ? FULL : IDLE;
            end
            DONE: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // datapath / output logic
    always_comb begin
        fields_d = fields_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        acc_d    = 1'b0;
        done_d   = done_q;
        if (bs_ev) begin
            if (cnt_q != '0) begin
                cnt_d    = cnt_q - CNT_W'(1);
                fields_d = fields_q & ~(TOT'(4'hF) << clr_shift);
            end else if (step_back) begin
                sel_d = sel_q - SEL_W'(1);
                cnt_d = CNT_FULL;
            end
        end else if (del_ev) begin
            fields_d = fields_q & ~(TOT'({W{1'b1}}) << sel_base);
            cnt_d    = '0;
        end else if (ent_ev) begin
            if (state == FULL) begin
                if (last_field) begin
                    done_d = 1'b1;
                end else begin
                    sel_d = sel_q + SEL_W'(1);
                    cnt_d = '0;
                end
            end
        end else if (hex_ev) begin
            fields_d = (fields_q & ~(TOT'(4'hF) << wr_shift)) |
                       (TOT'(digit) << wr_shift);
            cnt_d    = cnt_q + CNT_W'(1);
            acc_d    = 1'b1;
        end
    end

    assign fields         = fields_q;
    assign field_sel      = sel_q;
    assign char_count     = cnt_q;
    assign field_full     = full;
    assign hex_accept     = acc_q;
    assign input_complete = done_q;
    assign refresh        = rst && can_edit && !any_key;

endmodule

// File: tb/tb_hex_field_entry.sv
// tb_hex_field_entry: table vectors, hand sequences and randomized checks
// of hex_field_entry against a nibble-array reference model.

module tb_hex_field_entry;

    localparam int NF = 2;
    localparam int FN = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hex_onehot;
    logic        backspace;
    logic        delete;
    logic        enter;
    logic [31:0] fields;
    logic [0:0]  field_sel;
    logic [2:0]  char_count;
    logic        field_full;
    logic        hex_accept;
    logic        input_complete;
    logic        refresh;

    always #5 clk = ~clk;

    hex_field_entry #(
        .NUM_FIELDS(NF),
        .FIELD_NIBBLES(FN),
        .SEL_W(1),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hex_onehot(hex_onehot),
        .backspace(backspace),
        .delete(delete),
        .enter(enter),
        .fields(fields),
        .field_sel(field_sel),
        .char_count(char_count),
        .field_full(field_full),
        .hex_accept(hex_accept),
        .input_complete(input_complete),
        .refresh(refresh)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // reference model: fields as nibble arrays, plus a "waiting for release" lock
    logic [3:0] m_nib [NF][FN];
    int         m_sel;
    int         m_cnt;
    bit         m_done;
    bit         m_lock;
    bit         m_acc;

    function automatic logic [31:0] model_fields();
        logic [31:0] f = '0;
        for (int i = 0; i < NF; i++)
            for (int j = 0; j < FN; j++)
                f |= 32'(m_nib[i][j]) << (i * 4 * FN + 4 * (FN - 1 - j));
        return f;
    endfunction

    task automatic model_step(input logic r, input logic [15:0] h,
                              input logic b, input logic d, input logic e);
        m_acc = 0;
        if (!r) begin
            for (int i = 0; i < NF; i++)
                for (int j = 0; j < FN; j++) m_nib[i][j] = 4'd0;
            m_sel = 0; m_cnt = 0; m_done = 0; m_lock = 0;
            return;
        end
        if (m_done) return;
        if (m_lock) begin
            if (h == 16'd0 && !b && !d && !e) m_lock = 0;
            return;
        end
        if (b) begin
            if (m_cnt > 0) begin
                m_cnt--;
                m_nib[m_sel][m_cnt] = 4'd0;
            end
`ifdef HEX_FIELD_PREV_EN
            else if (m_sel > 0) begin
                m_sel--;
                m_cnt = FN;
            end
`endif
            m_lock = 1;
        end else if (d) begin
            for (int j = 0; j < FN; j++) m_nib[m_sel][j] = 4'd0;
            m_cnt = 0;
            m_lock = 1;
        end else if (e) begin
            if (m_cnt != FN) m_lock = 1;
            else if (m_sel < NF - 1) begin
                m_sel++; m_cnt = 0; m_lock = 1;
            end else m_done = 1;
        end else if ($countones(h) == 1 && m_cnt != FN) begin
            m_nib[m_sel][m_cnt] = 4'($clog2(h));
            m_cnt++;
            m_acc = 1;
            m_lock = 1;
        end
    endtask

    // one clock: drive inputs, step model with the same inputs at the edge
    task automatic tick(input logic r, input logic [15:0] h,
                        input logic b, input logic d, input logic e);
        rst = r; hex_onehot = h; backspace = b; delete = d; enter = e;
        @(posedge clk);
        model_step(r, h, b, d, e);
        #1;
    endtask

    task automatic typekey(input logic [15:0] h);
        tick(1, h, 0, 0, 0);
        tick(1, 16'd0, 0, 0, 0);
    endtask

    task automatic check_model(input string tag);
        bit keys0 = (hex_onehot == 16'd0) && !backspace && !delete && !enter;
        check({tag, ".fields"}, fields, model_fields());
        check({tag, ".sel"}, 32'(field_sel), 32'(m_sel));
        check({tag, ".cnt"}, 32'(char_count), 32'(m_cnt));
        check({tag, ".full"}, 32'(field_full), 32'(m_cnt == FN));
        check({tag, ".acc"}, 32'(hex_accept), 32'(m_acc));
        check({tag, ".done"}, 32'(input_complete), 32'(m_done));
        check({tag, ".refresh"}, 32'(refresh),
              32'(rst && !m_lock && !m_done && keys0));
    endtask

    typedef struct {
        logic [15:0] h;
        logic        b;
        logic        d;
        logic        e;
        logic [31:0] f;
        int          sel;
        int          cnt;
        logic        acc;
        logic        done;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [15:0] h, input logic b, input logic d,
                       input logic e, input logic [31:0] f, input int sel,
                       input int cnt, input logic acc, input logic done);
        vec_t v;
        v.h = h; v.b = b; v.d = d; v.e = e; v.f = f;
        v.sel = sel; v.cnt = cnt; v.acc = acc; v.done = done;
        tbl.push_back(v);
    endtask

    initial begin
        int pulses;
        rst = 1'b0; hex_onehot = '0; backspace = 0; delete = 0; enter = 0;

        // entry and completion table
        add(16'h0002, 0, 0, 0, 32'h0000_1000, 0, 1, 1, 0);
        add(16'h0000, 0, 0, 0, 32'h0000_1000, 0, 1, 0, 0);
        add(16'h0004, 0, 0, 0, 32'h0000_1200, 0, 2, 1, 0);
        add(16'h0000, 0, 0, 0, 32'h0000_1200, 0, 2, 0, 0);
        add(16'h0008, 0, 0, 0, 32'h0000_1230, 0, 3, 1, 0);
        add(16'h0000, 0, 0, 0, 32'h0000_1230, 0, 3, 0, 0);
        add(16'h0010, 0, 0, 0, 32'h0000_1234, 0, 4, 1, 0);
        add(16'h0000, 0, 0, 0, 32'h0000_1234, 0, 4, 0, 0);
        add(16'h8000, 0, 0, 0, 32'h0000_1234, 0, 4, 0, 0);
        add(16'h0000, 0, 0, 0, 32'h0000_1234, 0, 4, 0, 0);
        add(16'h0000, 0, 0, 1, 32'h0000_1234, 1, 0, 0, 0);
        add(16'h0000, 0, 0, 0, 32'h0000_1234, 1, 0, 0, 0);
        add(16'h0400, 0, 0, 0, 32'hA000_1234, 1, 1, 1, 0);
        add(16'h0000, 0, 0, 0, 32'hA000_1234, 1, 1, 0, 0);
        add(16'h0800, 0, 0, 0, 32'hAB00_1234, 1, 2, 1, 0);
        add(16'h0000, 0, 0, 0, 32'hAB00_1234, 1, 2, 0, 0);
        add(16'h1000, 0, 0, 0, 32'hABC0_1234, 1, 3, 1, 0);
        add(16'h0000, 0, 0, 0, 32'hABC0_1234, 1, 3, 0, 0);
        add(16'h2000, 0, 0, 0, 32'hABCD_1234, 1, 4, 1, 0);
        add(16'h0000, 0, 0, 0, 32'hABCD_1234, 1, 4, 0, 0);
        add(16'h0000, 0, 0, 1, 32'hABCD_1234, 1, 4, 0, 1);
        add(16'h0000, 0, 0, 0, 32'hABCD_1234, 1, 4, 0, 1);
        add(16'h0001, 0, 0, 0, 32'hABCD_1234, 1, 4, 0, 1);
        add(16'h0000, 1, 0, 0, 32'hABCD_1234, 1, 4, 0, 1);
        add(16'h0000, 0, 1, 0, 32'hABCD_1234, 1, 4, 0, 1);

        // reset with a key held
        tick(0, 16'h0008, 0, 0, 0);
        tick(0, 16'h0008, 0, 0, 0);
        check("rst.fields", fields, 32'h0);
        check("rst.sel", 32'(field_sel), 32'h0);
        check("rst.cnt", 32'(char_count), 32'h0);
        check("rst.acc", 32'(hex_accept), 32'h0);
        check("rst.done", 32'(input_complete), 32'h0);
        check("rst.refresh", 32'(refresh), 32'h0);
        rst = 1'b1; hex_onehot = '0;
        #1;
        check("rst.refresh_rel", 32'(refresh), 32'h1);

        pulses = 0;
        foreach (tbl[i]) begin
            tick(1, tbl[i].h, tbl[i].b, tbl[i].d, tbl[i].e);
            if (i < 10) pulses += int'(hex_accept);
            check($sformatf("tbl%0d.fields", i), fields, tbl[i].f);
            check($sformatf("tbl%0d.sel", i), 32'(field_sel), 32'(tbl[i].sel));
            check($sformatf("tbl%0d.cnt", i), 32'(char_count), 32'(tbl[i].cnt));
            check($sformatf("tbl%0d.full", i), 32'(field_full),
                  32'(tbl[i].cnt == FN));
            check($sformatf("tbl%0d.acc", i), 32'(hex_accept), 32'(tbl[i].acc));
            check($sformatf("tbl%0d.done", i), 32'(input_complete),
                  32'(tbl[i].done));
        end
        check("tbl.pulses", 32'(pulses), 32'd4);

        // reset pulse out of DONE
        tick(0, 16'h0, 0, 0, 0);
        check("done_rst.fields", fields, 32'h0);
        check("done_rst.sel", 32'(field_sel), 32'h0);
        check("done_rst.cnt", 32'(char_count), 32'h0);
        check("done_rst.done", 32'(input_complete), 32'h0);

        // hold debounce
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1, 16'h0080, 0, 0, 0);
            pulses += int'(hex_accept);
        end
        tick(1, 16'h0, 0, 0, 0);
        check("hold.pulses", 32'(pulses), 32'd1);
        check("hold.fields", fields, 32'h0000_7000);
        check("hold.cnt", 32'(char_count), 32'd1);

        // edits on 12__
        tick(0, 16'h0, 0, 0, 0);
        typekey(16'h0002);
        typekey(16'h0004);
        tick(1, 16'h0, 1, 0, 0);
        check("bs.cnt", 32'(char_count), 32'd1);
        check("bs.fields", fields, 32'h0000_1000);
        tick(1, 16'h0, 0, 0, 0);
        tick(1, 16'h0, 0, 1, 0);
        check("del.fields", fields, 32'h0);
        check("del.cnt", 32'(char_count), 32'd0);
        tick(1, 16'h0, 0, 0, 0);
        tick(1, 16'h0, 1, 0, 0);
        check("bs0.fields", fields, 32'h0);
        check("bs0.cnt", 32'(char_count), 32'd0);
        check("bs0.sel", 32'(field_sel), 32'd0);
        tick(1, 16'h0, 0, 0, 0);

        // priority and invalid input
        tick(0, 16'h0, 0, 0, 0);
        typekey(16'h0002);
        typekey(16'h0004);
        tick(1, 16'h0200, 1, 0, 0);
        check("prio.cnt", 32'(char_count), 32'd1);
        check("prio.fields", fields, 32'h0000_1000);
        check("prio.acc", 32'(hex_accept), 32'd0);
        tick(1, 16'h0, 0, 0, 0);
        tick(1, 16'h0011, 0, 0, 0);
        check("inv.cnt", 32'(char_count), 32'd1);
        check("inv.acc", 32'(hex_accept), 32'd0);
        check("inv.fields", fields, 32'h0000_1000);
        tick(1, 16'h0, 0, 0, 0);
        tick(1, 16'h0, 0, 0, 1);
        check("ent_nf.sel", 32'(field_sel), 32'd0);
        tick(1, 16'h0, 0, 0, 0);

        // step back into a committed field
        tick(0, 16'h0, 0, 0, 0);
        typekey(16'h0002);
        typekey(16'h0004);
        typekey(16'h0008);
        typekey(16'h0010);
        tick(1, 16'h0, 0, 0, 1);
        tick(1, 16'h0, 0, 0, 0);
        check("prev.sel1", 32'(field_sel), 32'd1);
        tick(1, 16'h0, 1, 0, 0);
`ifdef HEX_FIELD_PREV_EN
        check("prev.sel", 32'(field_sel), 32'd0);
        check("prev.cnt", 32'(char_count), 32'd4);
        tick(1, 16'h0, 0, 0, 0);
        tick(1, 16'h0, 1, 0, 0);
        check("prev.fields", fields, 32'h0000_1230);
        check("prev.cnt2", 32'(char_count), 32'd3);
`else
        check("noprev.sel", 32'(field_sel), 32'd1);
        check("noprev.cnt", 32'(char_count), 32'd0);
        check("noprev.fields", fields, 32'h0000_1234);
`endif
        tick(1, 16'h0, 0, 0, 0);

        // randomized run against the model
        tick(0, 16'h0, 0, 0, 0);
        check_model("rnd_rst");
        for (int n = 0; n < 3000; n++) begin
            logic        r;
            logic [15:0] h;
            logic        b;
            logic        d;
            logic        e;
            int          kind;
            int          a;
            int          c;
            r = ($urandom_range(0, 199) != 0);
            h = '0; b = 0; d = 0; e = 0;
            kind = $urandom_range(0, 15);
            if (kind >= 7 && kind <= 10) begin
                h = 16'd1 << $urandom_range(0, 15);
            end else if (kind == 11) begin
                a = $urandom_range(0, 15);
                c = (a + $urandom_range(1, 15)) % 16;
                h = (16'd1 << a) | (16'd1 << c);
            end else if (kind == 12) begin
                b = 1;
            end else if (kind == 13) begin
                d = ($urandom_range(0, 2) == 0);
            end else if (kind == 14) begin
                e = 1;
            end else if (kind == 15) begin
                h = 16'($urandom);
                b = 1'($urandom);
                d = 1'($urandom);
                e = 1'($urandom);
            end
            tick(r, h, b, d, e);
            check_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
